simon_sequencer: RTL and testbench
==================================

// Module: simon_sequencer
// PURPOSE
//  Game-level sequencer for Simon Says. Grows a random direction sequence one step per round,
//  plays it back by driving the arrow-highlight drawing FSM (show_on/show_dir), then checks
//  player key presses against it. Sits between the keypad decoder and the arrow drawing FSM.
//  Declares win after MAX_LEN correct rounds; loss on a wrong key or an input timeout.
// PARAMETERS
//  MAX_LEN        16          sequence length needed to win (2..64)
//  SHOW_CYCLES    25_000_000  cycles an arrow stays highlighted
//  GAP_CYCLES     12_500_000  dark gap after each arrow and between rounds
//  TIMEOUT_CYCLES 100_000_000 max cycles between accepted keys in WAIT_KEY
//  LFSR_SEED      16'hACE1    LFSR reset value; must be nonzero
// PORTS
//  clock       in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  start       in   1   one-cycle pulse; begins a new game from IDLE, WIN or LOSE
//  key_valid   in   1   one-cycle pulse; player pressed key_dir
//  key_dir     in   2   00 up, 01 down, 10 right, 11 left
//  show_on     out  1   high while an arrow is highlighted
//  show_dir    out  2   arrow to highlight; valid while show_on=1
//  key_ok      out  1   one-cycle pulse, the cycle after an accepted matching key
//  busy        out  1   high in every state except IDLE, WIN, LOSE
//  win         out  1   level; high in WIN
//  lose        out  1   level; high in LOSE
//  round_len   out  $clog2(MAX_LEN+1)  current sequence length
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; round_len 0; idx, timers 0; lfsr=LFSR_SEED; seq contents don't-care.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle (including IDLE), never loads 0.
//  States and transitions (timers count from 0; a state lasting N cycles exits on count N-1):
//   IDLE     : start -> GEN (round_len cleared to 0).
//   GEN      : 1 cycle; seq[round_len]<=lfsr[1:0]; round_len++; idx<=0 -> SHOW_ON.
//   SHOW_ON  : SHOW_CYCLES cycles; show_on=1, show_dir=seq[idx] -> SHOW_OFF.
//   SHOW_OFF : GAP_CYCLES cycles, show_on=0; at exit idx++; new idx==round_len -> WAIT_KEY
//              (idx<=0, timeout timer cleared), else -> SHOW_ON.
//   WAIT_KEY : key_valid & key_dir!=seq[idx] -> LOSE.
//              key_valid & match & idx<round_len-1 -> idx++, timer cleared, key_ok next cycle.
//              key_valid & match & idx==round_len-1 -> key_ok; round_len==MAX_LEN ? WIN : ROUND_GAP.
//              no key for TIMEOUT_CYCLES cycles -> LOSE.
//   ROUND_GAP: GAP_CYCLES cycles -> GEN.
//   WIN/LOSE : hold; start -> GEN with round_len cleared (new game, LFSR not reseeded).
//  Boundaries:
//   key_valid outside WAIT_KEY ignored (no key_ok, no state change).
//   start outside IDLE/WIN/LOSE ignored. start and key_valid same cycle in WAIT_KEY: key wins.
//   key_valid on the exact timeout cycle: key is evaluated, timeout ignored.
//   reset mid-operation: immediate return to reset values next edge; show_on drops.
//   round_len saturates at MAX_LEN; never wraps.
//  Timers: one shared down/up counter, width $clog2(max of the three cycle params)+1.
// STRUCTURE
//  Shared package simon_pkg: direction encodings (DIR_UP/DOWN/RIGHT/LEFT), state enum,
//  LFSR tap constant. Sub-module simon_lfsr16 (seed param, enable, 16-bit state out).
//  Sequence store: MAX_LEN x 2-bit register array, written only in GEN.
// TESTING (bench params: MAX_LEN=4, SHOW=4, GAP=2, TIMEOUT=20; reference LFSR model in bench)
//  1 reset, no start -> all outputs 0 for 100 cycles; start -> busy=1 next cycle, round_len=1.
//  2 round 1 -> show_on high exactly 4 cycles with show_dir=model[0], then 2 dark cycles, WAIT_KEY.
//  3 correct keys rounds 1..4 -> key_ok pulse per key, round_len 1,2,3,4, then win=1, busy=0.
//  4 round 2, second key wrong -> lose=1 next cycle, no key_ok; start -> round_len=1, GEN replays.
//  5 no key for 20 cycles in WAIT_KEY -> lose=1; key on cycle 20 instead -> accepted.
//  6 keys pressed during SHOW_ON ignored; reset asserted mid-SHOW_ON -> show_on=0, IDLE next edge.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says game sequencer: direction codes,
// sequencer states and the 16-bit Fibonacci LFSR step.
package simon_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_KEY,
    ST_ROUND_GAP,
    ST_WIN,
    ST_LOSE
  } state_e;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the direction source.
module simon_lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clock) begin
    if (reset)   state <= SEED;
    else if (en) state <= lfsr_step(state);
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game sequencer: grows a random direction sequence, plays it back
// on show_on/show_dir, then checks the player's keys against it.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 25_000_000,
  parameter int          GAP_CYCLES     = 12_500_000,
  parameter int          TIMEOUT_CYCLES = 100_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         key_valid,
  input  logic [1:0]                   key_dir,
  output logic                         show_on,
  output logic [1:0]                   show_dir,
  output logic                         key_ok,
  output logic                         busy,
  output logic                         win,
  output logic                         lose,
  output logic [$clog2(MAX_LEN+1)-1:0] round_len
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = $clog2(MAX_LEN);
  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES)
                        ? ((SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES)
                        : ((GAP_CYCLES  > TIMEOUT_CYCLES) ? GAP_CYCLES  : TIMEOUT_CYCLES);
  localparam int TW   = $clog2(MAXC) + 1;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] MAX_L     = LW'(MAX_LEN);

  state_e          state;
  logic [TW-1:0]   timer;
  logic [LW-1:0]   idx;
  logic [LW-1:0]   idx_nxt;
  logic [1:0]      seq [MAX_LEN];
  logic [15:0]     lfsr;
  logic            lfsr_unused;

  simon_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .state (lfsr)
  );

  // Only the two low bits pick a direction; the rest just feed the shift chain
  assign lfsr_unused = ^lfsr[15:2];
  assign idx_nxt     = idx + 1'b1;

  // Sequence store carries no reset: entries are always written before being read
  always_ff @(posedge clock) begin
    if (!reset && state == ST_GEN && round_len < MAX_L)
      seq[round_len[IW-1:0]] <= lfsr[1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      idx       <= '0;
      round_len <= '0;
      show_on   <= 1'b0;
      show_dir  <= 2'b00;
      key_ok    <= 1'b0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      key_ok <= 1'b0;
      case (state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start) begin
            state     <= ST_GEN;
            round_len <= '0;
            busy      <= 1'b1;
            win       <= 1'b0;
            lose      <= 1'b0;
          end
        end

        ST_GEN: begin
          if (round_len != MAX_L) round_len <= round_len + 1'b1;
          idx     <= '0;
          timer   <= '0;
          show_on <= 1'b1;
          // seq[0] is being written this very cycle on the first round
          show_dir <= (round_len == '0) ? lfsr[1:0] : seq[0];
          state    <= ST_SHOW_ON;
        end

        ST_SHOW_ON: begin
          if (timer == SHOW_LAST) begin
            timer   <= '0;
            show_on <= 1'b0;
            state   <= ST_SHOW_OFF;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_SHOW_OFF: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (idx_nxt == round_len) begin
              idx   <= '0;
              state <= ST_WAIT_KEY;
            end else begin
              idx      <= idx_nxt;
              show_on  <= 1'b1;
              show_dir <= seq[idx_nxt[IW-1:0]];
              state    <= ST_SHOW_ON;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_WAIT_KEY: begin
          // A key on the timeout cycle is still evaluated
          if (key_valid) begin
            timer <= '0;
            if (key_dir != seq[idx[IW-1:0]]) begin
              state <= ST_LOSE;
              lose  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              key_ok <= 1'b1;
              if (idx_nxt != round_len) begin
                idx <= idx_nxt;
              end else begin
                idx <= '0;
                if (round_len == MAX_L) begin
                  state <= ST_WIN;
                  win   <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  state <= ST_ROUND_GAP;
                end
              end
            end
          end else if (timer == TO_LAST) begin
            timer <= '0;
            state <= ST_LOSE;
            lose  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_ROUND_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= ST_GEN;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with a reference LFSR supplying the expected directions.
module tb_simon_sequencer;

  localparam int          MAX_LEN = 4;
  localparam int          SHOW    = 4;
  localparam int          GAP     = 2;
  localparam int          TO      = 20;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_dir = 2'b00;
  logic       show_on;
  logic [1:0] show_dir;
  logic       key_ok, busy, win, lose;
  logic [2:0] round_len;

  always #5 clock = ~clock;

  simon_sequencer #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .key_valid(key_valid),
    .key_dir(key_dir), .show_on(show_on), .show_dir(show_dir), .key_ok(key_ok),
    .busy(busy), .win(win), .lose(lose), .round_len(round_len)
  );

  // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting left, new bit enters at bit 0
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clock) m_lfsr <= reset ? SEED : ref_step(m_lfsr);

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_seq [MAX_LEN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [1:0] d);
    key_valid = 1'b1;
    key_dir   = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_flags", {win, lose}, 0);
    chk("gen_len0", round_len, 0);
    exp_seq[0] = m_lfsr[1:0];
    tick();
    chk("round_len_1", round_len, 1);
  endtask

  task automatic play_round(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < SHOW; c++) begin
        chk("show_on", show_on, 1);
        chk("show_dir", show_dir, exp_seq[i]);
        tick();
      end
      for (int c = 0; c < GAP; c++) begin
        chk("show_gap", show_on, 0);
        tick();
      end
    end
  endtask

  // Called just after the last key of round n was accepted (n < MAX_LEN)
  task automatic next_round(input int n);
    chk("gap_busy", busy, 1);
    tick();
    chk("key_ok_drop", key_ok, 0);
    tick();
    exp_seq[n] = m_lfsr[1:0];
    tick();
    chk("round_len", round_len, n + 1);
  endtask

  task automatic enter_keys(input int n, input bit with_start);
    for (int i = 0; i < n; i++) begin
      start = with_start && (i == 0);
      press(exp_seq[i]);
      start = 1'b0;
      chk("key_ok", key_ok, 1);
      chk("key_no_lose", lose, 0);
    end
    if (n == MAX_LEN) begin
      chk("win", win, 1);
      chk("win_busy", busy, 0);
      chk("win_len", round_len, MAX_LEN);
    end else begin
      next_round(n);
    end
  endtask

  task automatic wait_idle_keys(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      chk("wait_no_lose", {lose, busy}, 2'b01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset_state", {show_on, show_dir, key_ok, busy, win, lose, round_len}, 0);
    reset = 1'b0;

    // Idle with no start; a stray key must do nothing
    for (int c = 0; c < 100; c++) begin
      if (c == 50) begin key_valid = 1'b1; key_dir = 2'b10; end
      tick();
      key_valid = 1'b0;
      chk("idle_quiet", {show_on, show_dir, key_ok, busy, win, lose, round_len}, 0);
    end

    // Full game to a win; start collides with a key in round 3
    start_game();
    play_round(1); enter_keys(1, 1'b0);
    play_round(2); enter_keys(2, 1'b0);
    play_round(3); enter_keys(3, 1'b1);
    play_round(4); enter_keys(4, 1'b0);
    tick();
    chk("win_ok_drop", key_ok, 0);
    press(2'b00);
    chk("win_key_ignored", key_ok, 0);
    chk("win_hold", {win, busy}, 2'b10);

    // Wrong second key in round 2
    start_game();
    play_round(1); enter_keys(1, 1'b0);
    play_round(2);
    press(exp_seq[0]);
    chk("r2_key1_ok", key_ok, 1);
    press(exp_seq[1] ^ 2'b01);
    chk("wrong_lose", lose, 1);
    chk("wrong_no_ok", key_ok, 0);
    chk("wrong_busy", busy, 0);

    // Restart from LOSE, then time out
    start_game();
    play_round(1);
    wait_idle_keys(TO - 1);
    tick();
    chk("timeout_lose", {lose, busy}, 2'b10);

    // Key on the exact timeout cycle is accepted
    start_game();
    play_round(1);
    wait_idle_keys(TO - 1);
    press(exp_seq[0]);
    chk("edge_key_ok", key_ok, 1);
    chk("edge_no_lose", lose, 0);
    next_round(1);

    // Keys during SHOW_ON ignored, then reset mid-show
    chk("show2_on", show_on, 1);
    press(~exp_seq[0]);
    chk("show_key_ign", {key_ok, lose}, 0);
    chk("show_still_on", show_on, 1);
    reset = 1'b1;
    tick();
    chk("reset_mid", {show_on, show_dir, key_ok, busy, win, lose, round_len}, 0);
    reset = 1'b0;
    tick();
    chk("post_reset_idle", {show_on, busy, round_len}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
